// File: rtl/mdio_phy_responder.sv
// Clause 22 MDIO PHY-side responder: oversamples MDC/MDIO, serves a small register file.
// Optional: define MDIO_PREAMBLE_SUPPRESS_EN to accept frames with a short/absent preamble.
module mdio_phy_responder #(
  parameter int unsigned NUM_REGS     = 8,
  parameter logic [15:0] PHY_ID1      = 16'h0007,
  parameter logic [15:0] PHY_ID2      = 16'hC0F1,
  parameter logic [15:0] BMCR_DEFAULT = 16'h3100
) (
  input  logic        msoc_clk,
  input  logic        rstn,
  input  logic        mdc,
  input  logic        mdio_i,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic [4:0]  phy_addr,
  input  logic        link_up,
  output logic        reg_wr,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data,
  output logic        soft_rst
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
  localparam logic [5:0] PreMin    = 6'd1;
  localparam logic       PreSupCap = 1'b1;
`else
  localparam logic [5:0] PreMin    = 6'd32;
  localparam logic       PreSupCap = 1'b0;
`endif

  typedef enum logic [3:0] {
    StIdle, StSt, StOp, StPhyad, StRegad, StTa, StWdata, StRdata, StSkip
  } state_e;

  logic r_mdc_s1, r_mdc_s2, r_mdc_s3, r_mdio_s1, r_mdio_s2;
  logic w_mdc_rise, w_mdc_fall, w_bit;

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      r_mdc_s1  <= 1'b0;
      r_mdc_s2  <= 1'b0;
      r_mdc_s3  <= 1'b0;
      r_mdio_s1 <= 1'b0;
      r_mdio_s2 <= 1'b0;
    end else begin
      r_mdc_s1  <= mdc;
      r_mdc_s2  <= r_mdc_s1;
      r_mdc_s3  <= r_mdc_s2;
      r_mdio_s1 <= mdio_i;
      r_mdio_s2 <= r_mdio_s1;
    end
  end

  assign w_mdc_rise = r_mdc_s2 & ~r_mdc_s3;
  assign w_mdc_fall = ~r_mdc_s2 & r_mdc_s3;
  assign w_bit      = r_mdio_s2;

  state_e      r_state;
  logic [4:0]  r_bit_cnt;
  logic [5:0]  r_pre_cnt;
  logic [15:0] r_shift;
  logic        r_is_read;
  logic        r_mismatch;
  logic [4:0]  r_reg_addr;
  logic [15:0] r_rd_data;
  logic        r_wr_pend;
  logic [15:0] r_regs [NUM_REGS];

  logic [4:0]  w_low5;
  logic [15:0] w_rd_val;

  // Low five bits including the bit being sampled now (PHYAD / REGAD on their 5th bit).
  assign w_low5 = {r_shift[3:0], w_bit};

  always_comb begin
    w_rd_val = 16'h0000;
    case (w_low5)
      5'd1:    w_rd_val = 16'h7809 | {9'b0, PreSupCap, 3'b0, link_up, 2'b0};
      5'd2:    w_rd_val = PHY_ID1;
      5'd3:    w_rd_val = PHY_ID2;
      default: begin
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_low5 == 5'(i)) w_rd_val = r_regs[i];
        end
      end
    endcase
  end

  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= StIdle;
      r_bit_cnt   <= 5'd0;
      r_pre_cnt   <= 6'd0;
      r_shift     <= 16'h0000;
      r_is_read   <= 1'b0;
      r_mismatch  <= 1'b0;
      r_reg_addr  <= 5'd0;
      r_rd_data   <= 16'h0000;
      r_wr_pend   <= 1'b0;
      mdio_o      <= 1'b0;
      mdio_oe     <= 1'b0;
      reg_wr      <= 1'b0;
      reg_wr_addr <= 5'd0;
      reg_wr_data <= 16'h0000;
      soft_rst    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= (i == 0) ? BMCR_DEFAULT : 16'h0000;
    end else begin
      reg_wr   <= 1'b0;
      soft_rst <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_mdc_rise) begin
            if (w_bit) begin
              if (r_pre_cnt != 6'd32) r_pre_cnt <= r_pre_cnt + 6'd1;
            end else begin
              if (r_pre_cnt >= PreMin) begin
                r_state   <= StSt;
                r_bit_cnt <= 5'd0;
              end
              r_pre_cnt <= 6'd0;
            end
          end
        end
        StSt: begin
          if (w_mdc_rise) begin
            r_state   <= w_bit ? StOp : StIdle;
            r_bit_cnt <= 5'd0;
          end
        end
        StOp: begin
          if (w_mdc_rise) begin
            r_shift <= {r_shift[14:0], w_bit};
            if (r_bit_cnt == 5'd0) begin
              r_bit_cnt <= 5'd1;
            end else begin
              r_bit_cnt  <= 5'd0;
              r_mismatch <= 1'b0;
              if ({r_shift[0], w_bit} == 2'b10) begin
                r_is_read <= 1'b1;
                r_state   <= StPhyad;
              end else if ({r_shift[0], w_bit} == 2'b01) begin
                r_is_read <= 1'b0;
                r_state   <= StPhyad;
              end else begin
                r_state <= StIdle;
              end
            end
          end
        end
        StPhyad: begin
          if (w_mdc_rise) begin
            r_shift <= {r_shift[14:0], w_bit};
            if (r_bit_cnt == 5'd4) begin
              r_mismatch <= (w_low5 != phy_addr);
              r_bit_cnt  <= 5'd0;
              r_state    <= StRegad;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        StRegad: begin
          if (w_mdc_rise) begin
            r_shift <= {r_shift[14:0], w_bit};
            if (r_bit_cnt == 5'd4) begin
              // Snapshot now so the returned word cannot change mid-shift.
              r_reg_addr <= w_low5;
              r_rd_data  <= w_rd_val;
              r_bit_cnt  <= 5'd0;
              r_state    <= r_mismatch ? StSkip : StTa;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        StTa: begin
          if (r_is_read) begin
            if (w_mdc_fall) begin
              if (r_bit_cnt == 5'd0) begin
                r_bit_cnt <= 5'd1;
              end else begin
                mdio_oe   <= 1'b1;
                mdio_o    <= 1'b0;
                r_bit_cnt <= 5'd0;
                r_state   <= StRdata;
              end
            end
          end else if (w_mdc_rise) begin
            if (r_bit_cnt == 5'd0) begin
              r_bit_cnt <= 5'd1;
            end else begin
              r_bit_cnt <= 5'd0;
              r_state   <= StWdata;
            end
          end
        end
        StRdata: begin
          if (w_mdc_fall) begin
            if (r_bit_cnt == 5'd16) begin
              mdio_oe   <= 1'b0;
              mdio_o    <= 1'b0;
              r_bit_cnt <= 5'd0;
              r_state   <= StIdle;
            end else begin
              mdio_o    <= r_rd_data[15];
              r_rd_data <= {r_rd_data[14:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        StWdata: begin
          if (r_wr_pend) begin
            r_wr_pend   <= 1'b0;
            reg_wr      <= 1'b1;
            reg_wr_addr <= r_reg_addr;
            reg_wr_data <= r_shift;
            r_bit_cnt   <= 5'd0;
            r_state     <= StIdle;
            if (r_reg_addr == 5'd0 && r_shift[15]) begin
              soft_rst <= 1'b1;
              for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= (i == 0) ? BMCR_DEFAULT : 16'h0000;
            end else begin
              for (int i = 0; i < NUM_REGS; i++) begin
                if ((i == 0 || i >= 4) && r_reg_addr == 5'(i)) r_regs[i] <= r_shift;
              end
            end
          end else if (w_mdc_rise) begin
            r_shift <= {r_shift[14:0], w_bit};
            if (r_bit_cnt == 5'd15) r_wr_pend <= 1'b1;
            else                    r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        StSkip: begin
          if (w_mdc_rise) begin
            if (r_bit_cnt == 5'd17) begin
              r_bit_cnt <= 5'd0;
              r_state   <= StIdle;
            end else begin
              r_bit_cnt <= r_bit_cnt + 5'd1;
            end
          end
        end
        default: begin
          r_state   <= StIdle;
          r_bit_cnt <= 5'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: bit-banged MDC/MDIO master with hand-computed expectations.
module tb_mdio_phy_responder;

  logic        msoc_clk = 1'b0;
  logic        rstn;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  phy_addr;
  logic        link_up;
  logic        reg_wr;
  logic [4:0]  reg_wr_addr;
  logic [15:0] reg_wr_data;
  logic        soft_rst;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int soft_cnt = 0;

  always #5 msoc_clk = ~msoc_clk;

  mdio_phy_responder dut (
    .msoc_clk    (msoc_clk),
    .rstn        (rstn),
    .mdc         (mdc),
    .mdio_i      (mdio_i),
    .mdio_o      (mdio_o),
    .mdio_oe     (mdio_oe),
    .phy_addr    (phy_addr),
    .link_up     (link_up),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .soft_rst    (soft_rst)
  );

  always @(posedge msoc_clk) begin
    if (reg_wr)   wr_cnt   <= wr_cnt + 1;
    if (soft_rst) soft_cnt <= soft_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One MDC period: drive on the low phase, sample the responder just before the rise.
  task automatic mdc_cycle(input logic b, output logic o, output logic oe);
    mdc    = 1'b0;
    mdio_i = b;
    repeat (10) @(negedge msoc_clk);
    o  = mdio_o;
    oe = mdio_oe;
    mdc = 1'b1;
    repeat (10) @(negedge msoc_clk);
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    logic o, oe;
    for (int i = n - 1; i >= 0; i--) mdc_cycle(v[i], o, oe);
  endtask

  task automatic header(input int pre, input logic [1:0] op, input logic [4:0] pa,
                        input logic [4:0] ra);
    logic o, oe;
    for (int i = 0; i < pre; i++) mdc_cycle(1'b1, o, oe);
    send_bits(32'b01, 2);
    send_bits({30'b0, op}, 2);
    send_bits({27'b0, pa}, 5);
    send_bits({27'b0, ra}, 5);
  endtask

  task automatic do_write(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] d);
    header(pre, 2'b01, pa, ra);
    send_bits(32'b10, 2);
    send_bits({16'b0, d}, 16);
    repeat (20) @(negedge msoc_clk);
  endtask

  // trace = {oe at TA1, oe at TA2, oe on all data bits, oe on any data bit, oe after bit 0}
  task automatic do_read(input int pre, input logic [4:0] pa, input logic [4:0] ra,
                         input int toggle_at, input int rst_at,
                         output logic [15:0] d, output logic [4:0] trace, output logic oe_rst);
    logic o, oe, ta1, ta2, all_oe, any_oe;
    oe_rst = 1'b1;
    header(pre, 2'b10, pa, ra);
    mdc_cycle(1'b1, o, oe);
    ta1 = oe;
    mdc_cycle(1'b1, o, oe);
    ta2 = oe;
    all_oe = 1'b1;
    any_oe = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == toggle_at) link_up = ~link_up;
      if (i == rst_at) begin
        rstn = 1'b0;
        #1;
        oe_rst = mdio_oe;
      end
      mdc_cycle(1'b1, o, oe);
      d[15-i] = o;
      all_oe &= oe;
      any_oe |= oe;
    end
    mdc_cycle(1'b1, o, oe);
    trace = {ta1, ta2, all_oe, any_oe, oe};
    rstn = 1'b1;
    repeat (20) @(negedge msoc_clk);
  endtask

  logic [15:0] rd;
  logic [4:0]  tr;
  logic        oe_r;
  int          w0, s0;

  initial begin
    rstn     = 1'b0;
    mdc      = 1'b1;
    mdio_i   = 1'b1;
    link_up  = 1'b0;
    phy_addr = 5'd1;
    repeat (5) @(negedge msoc_clk);
    check("rst_mdio_oe", {31'b0, mdio_oe}, 32'd0);
    check("rst_mdio_o", {31'b0, mdio_o}, 32'd0);
    check("rst_reg_wr", {31'b0, reg_wr}, 32'd0);
    check("rst_wr_addr", {27'b0, reg_wr_addr}, 32'd0);
    check("rst_wr_data", {16'b0, reg_wr_data}, 32'd0);
    check("rst_soft_rst", {31'b0, soft_rst}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge msoc_clk);

    do_read(32, 5'd1, 5'd2, -1, -1, rd, tr, oe_r);
    check("rd_id1", {16'b0, rd}, 32'h0007);
    check("rd_oe_trace", {27'b0, tr}, 32'b01110);

    w0 = wr_cnt;
    do_write(32, 5'd1, 5'd5, 16'hA5A5);
    check("wr5_pulses", wr_cnt - w0, 32'd1);
    check("wr5_addr", {27'b0, reg_wr_addr}, 32'd5);
    check("wr5_data", {16'b0, reg_wr_data}, 32'hA5A5);
    do_read(32, 5'd1, 5'd5, -1, -1, rd, tr, oe_r);
    check("rd5", {16'b0, rd}, 32'hA5A5);

    link_up = 1'b1;
    do_read(32, 5'd1, 5'd1, 4, -1, rd, tr, oe_r);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("rd_bmsr_snap", {16'b0, rd}, 32'h784D);
`else
    check("rd_bmsr_snap", {16'b0, rd}, 32'h780D);
`endif
    link_up = 1'b0;

    do_write(32, 5'd1, 5'd5, 16'h1234);
    s0 = soft_cnt;
    do_write(32, 5'd1, 5'd0, 16'h8000);
    check("soft_rst_pulse", soft_cnt - s0, 32'd1);
    check("wr0_addr", {27'b0, reg_wr_addr}, 32'd0);
    check("wr0_data", {16'b0, reg_wr_data}, 32'h8000);
    do_read(32, 5'd1, 5'd0, -1, -1, rd, tr, oe_r);
    check("rd0_after_srst", {16'b0, rd}, 32'h3100);
    do_read(32, 5'd1, 5'd5, -1, -1, rd, tr, oe_r);
    check("rd5_after_srst", {16'b0, rd}, 32'h0000);

    w0 = wr_cnt;
    do_write(32, 5'd1, 5'd2, 16'hFFFF);
    check("wr_ro_pulses", wr_cnt - w0, 32'd1);
    check("wr_ro_addr", {27'b0, reg_wr_addr}, 32'd2);
    do_read(32, 5'd1, 5'd2, -1, -1, rd, tr, oe_r);
    check("rd_ro_kept", {16'b0, rd}, 32'h0007);
    do_read(32, 5'd1, 5'd9, -1, -1, rd, tr, oe_r);
    check("rd_unimpl", {16'b0, rd}, 32'h0000);

    w0 = wr_cnt;
    do_read(32, 5'd2, 5'd2, -1, -1, rd, tr, oe_r);
    check("skip_oe_trace", {27'b0, tr}, 32'b00000);
    do_write(32, 5'd2, 5'd4, 16'h5555);
    check("skip_no_wr", wr_cnt - w0, 32'd0);
    do_read(32, 5'd1, 5'd3, -1, -1, rd, tr, oe_r);
    check("rd_id2_after_skip", {16'b0, rd}, 32'hC0F1);

    w0 = wr_cnt;
    do_write(20, 5'd1, 5'd6, 16'hBEEF);
    do_read(20, 5'd1, 5'd2, -1, -1, rd, tr, oe_r);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("short_pre_wr", wr_cnt - w0, 32'd1);
    check("short_pre_rd_trace", {27'b0, tr}, 32'b01110);
`else
    check("short_pre_wr", wr_cnt - w0, 32'd0);
    check("short_pre_rd_trace", {27'b0, tr}, 32'b00000);
`endif
    do_read(32, 5'd1, 5'd6, -1, -1, rd, tr, oe_r);
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    check("short_pre_rd6", {16'b0, rd}, 32'hBEEF);
`else
    check("short_pre_rd6", {16'b0, rd}, 32'h0000);
`endif

    do_write(32, 5'd1, 5'd7, 16'h0F0F);
    do_read(32, 5'd1, 5'd2, -1, 5, rd, tr, oe_r);
    check("rst_mid_rdata_oe", {31'b0, oe_r}, 32'd0);
    do_read(32, 5'd1, 5'd2, -1, -1, rd, tr, oe_r);
    check("rd_after_rst", {16'b0, rd}, 32'h0007);
    check("rd_after_rst_trace", {27'b0, tr}, 32'b01110);
    do_read(32, 5'd1, 5'd7, -1, -1, rd, tr, oe_r);
    check("rd7_cleared_by_rst", {16'b0, rd}, 32'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mdio_phy_responder.md
Name: mdio_phy_responder

Overview:
PHY-side MDIO management responder (IEEE 802.3 Clause 22) and the counterpart of the MAC's bit-banged MDC/MDIO master. It oversamples MDC/MDIO on the system clock, decodes read/write frames addressed to its strapped PHY address, serves a small 16-bit register file, and drives MDIO during read turnaround and data. It is used as the PHY model in loopback SoC simulation and as a management endpoint in FPGA bring-up.

Parameters:
NUM_REGS, 8, number of implemented registers (addresses 0..NUM_REGS-1); minimum 4
PHY_ID1, 16'h0007, read-only value of reg 2
PHY_ID2, 16'hC0F1, read-only value of reg 3
BMCR_DEFAULT, 16'h3100, reset value of reg 0

Ports:
msoc_clk  in  1  system clock; all logic in this domain
rstn  in  1  asynchronous active-low reset
mdc  in  1  MDIO clock from the master; asynchronous to msoc_clk
mdio_i  in  1  MDIO line input
mdio_o  out  1  MDIO drive value
mdio_oe  out  1  MDIO output enable (1 = responder drives)
phy_addr  in  5  strapped PHY address; quasi-static
link_up  in  1  reflected in reg 1 bit 2
reg_wr  out  1  one-cycle pulse when a register write commits
reg_wr_addr  out  5  address of the committed write
reg_wr_data  out  16  data of the committed write
soft_rst  out  1  one-cycle pulse when BMCR bit 15 is written as 1

Behaviour:
- Reset (async, rstn=0): mdio_o=0, mdio_oe=0, reg_wr=0, reg_wr_addr=0, reg_wr_data=0, soft_rst=0. FSM goes to IDLE, preamble count is 0, and RW regs take their defaults (reg 0=BMCR_DEFAULT, others 0). Reset mid-frame releases MDIO immediately.
- mdc and mdio_i each pass through a 2-flop synchronizer. An edge register gives mdc_rise/mdc_fall pulses 3 cycles after the pin edge. MDC high and low times must each be at least 8 msoc_clk cycles.
- MDIO is sampled on mdc_rise (the synchronized mdio_i). The drive value changes 1 cycle after mdc_fall.
- FSM states: IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA, SKIP. A 5-bit bit counter is cleared on every state entry.
- IDLE: count consecutive sampled 1s, saturating at 32. A sampled 0 with count=32 enters ST (this 0 is ST bit 1). A 0 with count<32 clears the count.
- ST: sampled 1 enters OP. Sampled 0 goes to IDLE with count 0.
- OP, 2 bits: 10 is read, 01 is write. 00/11 go to IDLE with count 0.
- PHYAD, 5 bits MSB first: on a mismatch with phy_addr, enter SKIP after REGAD. Otherwise continue.
- REGAD, 5 bits: on the 5th bit, latch reg_addr. For a read, snapshot the read value: an unimplemented address gives 16'h0000; reg 1 gives 16'h7809 | (link_up<<2); reg 2 gives PHY_ID1; reg 3 gives PHY_ID2.
- TA, 2 sample periods.
  - Read: MDIO stays released on the first mdc_fall. On the second mdc_fall, drive mdio_oe=1 and mdio_o=0.
  - Write: TA samples are ignored.
- RDATA: on each of the next 16 mdc_fall, drive snapshot bit 15 down to bit 0. On the mdc_fall after bit 0, set mdio_oe=0 and mdio_o=0, then go to IDLE.
- WDATA: shift 16 sampled bits MSB first. One cycle after the 16th mdc_rise, commit and go to IDLE.
  - Commit targets: RW regs 0 and 4..NUM_REGS-1. Regs 1–3 and unimplemented addresses are not written, but reg_wr still pulses with the address and data.
  - Writing reg 0 with bit 15=1 pulses soft_rst and reloads every RW reg to its default (reg 0 reads BMCR_DEFAULT, bit 15 clear). This takes priority over the write data.
- SKIP: stay passive for 18 mdc_rise (TA plus data), then go to IDLE. The responder never drives in SKIP.
- After any frame completes, the preamble count restarts at 0, so the next frame needs a new preamble.
- A write from the link sets reg_wr_addr/reg_wr_data in the same cycle as the reg_wr pulse; both hold until the next write.

Optional Feature:
MDIO_PREAMBLE_SUPPRESS_EN
- Defined: IDLE accepts ST after at least 1 sampled 1, so frames with a short or suppressed preamble work. Reg 1 bit 6 (preamble suppression capable) reads 1.
- Undefined: a full 32-bit preamble is required and reg 1 bit 6 reads 0.

Test Plan:
- Reset, then read reg 2 at phy_addr=1 with 32-bit preamble → RDATA shifts 16'h0007. mdio_oe rises on the 2nd TA fall and drops after bit 0.
- Write 16'hA5A5 to reg 5, then read reg 5 → reg_wr pulses once with addr=5, data=A5A5. The read returns A5A5.
- link_up=1, read reg 1 → 16'h780D. Toggle link_up during RDATA → the returned value is unchanged (snapshot).
- Write reg 0 with 16'h8000 after a prior write of reg 5=1234 → soft_rst pulses. Reg 0 reads 3100 and reg 5 reads 0000.
- Read with PHYAD=2 while phy_addr=1 → mdio_oe stays 0 for the whole frame. The next valid frame is decoded correctly.
- Frame with a 20-bit preamble → ignored (mdio_oe=0, no reg_wr) without the macro. Decoded normally with MDIO_PREAMBLE_SUPPRESS_EN.
- Assert rstn mid-RDATA → mdio_oe=0 immediately. A subsequent full frame works.
